// File: rtl/hrange_running_sum_pkg.sv
// hrange_running_sum_pkg: shared state encoding, widths and saturating add for hrange_running_sum.
package hrange_running_sum_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2, DONE = 2'd3} state_t;
  localparam logic [DATA_W-1:0] SUM_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SUM_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] s;
    s = a + b;
    return (a[DATA_W-1] == b[DATA_W-1] && s[DATA_W-1] != a[DATA_W-1]) ? (a[DATA_W-1] ? SUM_MIN : SUM_MAX) : s;
  endfunction
endpackage

// File: rtl/hrange_running_sum_gen_out_buf.sv
// gen_out_buf: one-entry valid/ready holding register with pass-through and flush.
module gen_out_buf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         ready,
  output logic         full,
  output logic [W-1:0] data
);
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
      data <= push_data;
    end else if (full && ready) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/hrange_running_sum.sv
// hrange_running_sum: turns an hrange tuple stream into a (count, running sum) generator stream.
// Optional saturating sum when HRANGE_RUNNING_SUM_SATURATE_EN is defined.
module hrange_running_sum
  import hrange_running_sum_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic             _start,
  input  logic             _ready,
  input  logic             up_valid,
  input  logic             up_done,
  input  logic [WIDTH-1:0] up_0,
  input  logic [WIDTH-1:0] up_1,
  output logic             up_ready,
  output logic             _valid,
  output logic             _done,
  output logic [WIDTH-1:0] _0,
  output logic [WIDTH-1:0] _1
);
  state_t state, state_nx;
  logic [WIDTH-1:0] count, sum, count_nx, sum_nx;
  logic full, pop, accept, drained;
  logic unused_up_0;
  assign unused_up_0 = ^up_0;
  assign pop = full && _ready;
  assign drained = !full || pop;
  assign up_ready = state == RUN && drained;
  // an item offered while restarting belongs to the old stream and is dropped
  assign accept = up_ready && up_valid && !_start;
  assign count_nx = count + WIDTH'(1);
`ifdef HRANGE_RUNNING_SUM_SATURATE_EN
  assign sum_nx = sat_add(sum, up_1);
`else
  assign sum_nx = sum + up_1;
`endif
  assign _valid = full;
  assign _done = state == DONE;
  always_comb begin
    state_nx = state;
    if (_start) state_nx = RUN;
    else if (state == RUN && up_done) state_nx = (!accept && drained) ? DONE : FINISH;
    else if (state == FINISH && drained) state_nx = DONE;
  end
  always_ff @(posedge _clock) begin
    if (_reset) begin
      state <= IDLE;
      count <= '0;
      sum <= '0;
    end else begin
      state <= state_nx;
      if (_start) begin
        count <= '0;
        sum <= '0;
      end else if (accept) begin
        count <= count_nx;
        sum <= sum_nx;
      end
    end
  end
  gen_out_buf #(.W(2*WIDTH)) u_buf (
    .clk(_clock),
    .rst(_reset),
    .flush(_start),
    .push(accept),
    .push_data({count_nx, sum_nx}),
    .ready(_ready),
    .full(full),
    .data({_0, _1})
  );
endmodule

// File: tb/tb_hrange_running_sum.sv
// tb_hrange_running_sum: directed self-checking bench for hrange_running_sum.
module tb_hrange_running_sum;
  typedef logic [31:0] arr_t [5];
  logic _clock = 1'b0, _reset, _start, _ready, up_valid, up_done;
  logic [31:0] up_0, up_1;
  logic up_ready, _valid, _done;
  logic [31:0] _0, _1;
  int nvec = 0, nfail = 0;
  arr_t v_even = '{0, 2, 4, 6, 8};
  arr_t e_cnt = '{1, 2, 3, 4, 5};
  arr_t e_sum = '{0, 2, 6, 12, 20};
  arr_t v_ovf = '{32'h7FFF_FFFF, 1, 0, 0, 0};
`ifdef HRANGE_RUNNING_SUM_SATURATE_EN
  arr_t e_ovf = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0, 0};
`else
  arr_t e_ovf = '{32'h7FFF_FFFF, 32'h8000_0000, 0, 0, 0};
`endif

  hrange_running_sum #(.WIDTH(32)) dut (
    ._clock(_clock), ._reset(_reset), ._start(_start), ._ready(_ready),
    .up_valid(up_valid), .up_done(up_done), .up_0(up_0), .up_1(up_1),
    .up_ready(up_ready), ._valid(_valid), ._done(_done), ._0(_0), ._1(_1)
  );

  always #5 _clock = ~_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start();
    _start = 1'b1; _ready = 1'b0; up_valid = 1'b0; up_done = 1'b0;
    @(posedge _clock); #1;
    _start = 1'b0;
  endtask

  // upstream model presents vals[0..n-1] then holds up_done; stops early after `stop` accepts
  task automatic feed(input string tag, input arr_t vals, input arr_t ec, input arr_t es,
                      input int n, input int stop, input int mode, input int max_cyc);
    int idx = 0, k = 0;
    bit stalled = 0, acc;
    logic rdy;
    logic [31:0] p0 = 0, p1 = 0;
    for (int c = 0; c < max_cyc && !_done && !(stop < n && idx >= stop); c++) begin
      up_valid = idx < n;
      up_1 = idx < n ? vals[idx] : 32'd0;
      up_0 = idx;
      up_done = idx >= n;
      rdy = mode == 0 ? 1'b1 : (c % 3 == 0);
      _ready = rdy;
      #1;
      if (stalled) begin
        chk({tag, " hold_0"}, _0, p0);
        chk({tag, " hold_1"}, _1, p1);
      end
      if (_valid && !rdy) chk({tag, " up_ready_stall"}, {31'd0, up_ready}, 32'd0);
      if (_valid && rdy) begin
        if (k < n) begin
          chk({tag, " out_0"}, _0, ec[k]);
          chk({tag, " out_1"}, _1, es[k]);
        end
        k++;
      end
      stalled = _valid && !rdy;
      p0 = _0; p1 = _1;
      acc = up_valid && up_ready;
      @(posedge _clock); #1;
      if (acc) idx++;
    end
    if (stop >= n) begin
      chk({tag, " done"}, {31'd0, _done}, 32'd1);
      chk({tag, " items"}, k, n);
      chk({tag, " valid_at_done"}, {31'd0, _valid}, 32'd0);
    end
  endtask

  initial begin
    _reset = 1'b1; _start = 1'b0; _ready = 1'b1; up_valid = 1'b1; up_done = 1'b0;
    up_0 = 0; up_1 = 32'd7;
    repeat (2) @(posedge _clock);
    #1 _reset = 1'b0;
    @(posedge _clock); #1;
    chk("rst valid", {31'd0, _valid}, 32'd0);
    chk("rst done", {31'd0, _done}, 32'd0);
    chk("rst up_ready", {31'd0, up_ready}, 32'd0);
    chk("rst _0", _0, 32'd0);
    chk("rst _1", _1, 32'd0);

    start();
    feed("even", v_even, e_cnt, e_sum, 5, 5, 0, 40);
    @(posedge _clock); #1;
    chk("done held", {31'd0, _done}, 32'd1);

    start();
    feed("empty", v_even, e_cnt, e_sum, 0, 0, 0, 3);
    chk("empty keep _0", _0, 32'd5);
    chk("empty keep _1", _1, 32'd20);

    start();
    feed("stall", v_even, e_cnt, e_sum, 5, 5, 1, 80);

    start();
    feed("ovf", v_ovf, e_cnt, e_ovf, 2, 2, 0, 20);

    start();
    feed("cut", v_even, e_cnt, e_sum, 5, 2, 0, 20);
    start();
    feed("restart", v_even, e_cnt, e_sum, 3, 3, 0, 20);

    start();
    up_valid = 1'b1; up_1 = 32'd4; up_done = 1'b0; _ready = 1'b0;
    @(posedge _clock); #1;
    chk("pre-rst valid", {31'd0, _valid}, 32'd1);
    chk("pre-rst _1", _1, 32'd4);
    _reset = 1'b1;
    @(posedge _clock); #1;
    _reset = 1'b0;
    chk("mid-rst valid", {31'd0, _valid}, 32'd0);
    chk("mid-rst done", {31'd0, _done}, 32'd0);
    chk("mid-rst up_ready", {31'd0, up_ready}, 32'd0);
    chk("mid-rst _0", _0, 32'd0);
    chk("mid-rst _1", _1, 32'd0);
    start();
    feed("post-rst", v_even, e_cnt, e_sum, 5, 5, 0, 40);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
